// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests whole lines over the sysbus, splits each beat
// into 32-bit words and queues them with their PCs for the decode stage.
`ifndef SYSBUS_READ
`define SYSBUS_READ 1'b1
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'b0001
`endif

module fetch_unit #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int LINE_BYTES     = 64,
    parameter int FIFO_DEPTH     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [63:0]               entry,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    output logic                      bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      redirect_valid,
    input  logic [63:0]               redirect_pc,
    output logic                      inst_valid,
    input  logic                      inst_ready,
    output logic [31:0]               inst_data,
    output logic [63:0]               inst_pc,
    output logic                      halted
);
    localparam int IPB        = BUS_DATA_WIDTH / 32;
    localparam int BEAT_BYTES = BUS_DATA_WIDTH / 8;
    localparam int BPL        = LINE_BYTES / BEAT_BYTES;
    localparam int IPL        = LINE_BYTES / 4;
    localparam int BEAT_W     = (BPL > 1) ? $clog2(BPL) : 1;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam int TAG_INT    = (int'(`SYSBUS_READ) << 8) | (int'(`SYSBUS_MEMORY) << 12);
    localparam logic [BUS_TAG_WIDTH-1:0] READ_TAG = BUS_TAG_WIDTH'(TAG_INT);
    localparam logic [63:0] LINE_MASK = ~64'(LINE_BYTES - 1);

    typedef enum logic [1:0] {IDLE, REQ, READ} state_t;

    state_t                   r_state;
    logic [63:0]              r_fetchPc;
    logic [63:0]              r_lineAddr;
    logic [BEAT_W-1:0]        r_beat;
    logic                     r_reqCyc;
    logic [BUS_TAG_WIDTH-1:0] r_reqTag;
    logic                     r_drain;
    logic                     r_halted;
    logic [31:0]              r_memData [FIFO_DEPTH];
    logic [63:0]              r_memPc   [FIFO_DEPTH];
    logic [PTR_W-1:0]         r_head;
    logic [PTR_W-1:0]         r_tail;
    logic [CNT_W-1:0]         r_count;

    logic                     w_beatAcc;
    logic                     w_lastBeat;
    logic                     w_pop;
    logic                     w_canFetch;
    logic [CNT_W-1:0]         w_free;
    logic [CNT_W-1:0]         w_pushCount;
    logic                     w_zeroPush;
    logic                     w_stop;
    logic                     w_push   [IPB];
    logic [31:0]              w_word   [IPB];
    logic [63:0]              w_wordPc [IPB];
    logic [PTR_W-1:0]         w_slot   [IPB];
    logic                     w_unusedTag;

    assign w_unusedTag = ^bus_resptag;
    assign w_beatAcc   = (r_state == READ) && bus_respcyc;
    assign w_lastBeat  = w_beatAcc && (r_beat == BEAT_W'(BPL - 1));
    assign w_pop       = (r_count != '0) && inst_ready && !redirect_valid;
    assign w_free      = CNT_W'(FIFO_DEPTH) - r_count;
    assign w_canFetch  = !r_halted && (w_free >= CNT_W'(IPL));

    assign bus_reqcyc  = r_reqCyc;
    assign bus_req     = BUS_DATA_WIDTH'(r_lineAddr);
    assign bus_reqtag  = r_reqTag;
    assign bus_respack = w_beatAcc && !reset;
    assign inst_valid  = (r_count != '0);
    assign inst_data   = r_memData[r_head];
    assign inst_pc     = r_memPc[r_head];
    assign halted      = r_halted;

    // Words of a beat that pass the filter form one contiguous run, so each
    // one lands at the tail plus the number of words already taken this beat.
    always_comb begin
        w_pushCount = '0;
        w_zeroPush  = 1'b0;
        w_stop      = 1'b0;
        for (int i = 0; i < IPB; i++) begin
            w_word[i]   = bus_resp[32*i +: 32];
            w_wordPc[i] = r_lineAddr + (64'(r_beat) * 64'(BEAT_BYTES)) + 64'(4 * i);
            w_push[i]   = 1'b0;
            w_slot[i]   = r_tail + PTR_W'(w_pushCount);
            if (w_beatAcc && !redirect_valid && !r_halted && !r_drain && !w_stop &&
                (w_wordPc[i] >= r_fetchPc) &&
                ((r_count + w_pushCount) < CNT_W'(FIFO_DEPTH))) begin
                w_push[i]   = 1'b1;
                w_pushCount = w_pushCount + CNT_W'(1);
                if (w_word[i] == 32'h0) begin
                    w_stop     = 1'b1;
                    w_zeroPush = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < IPB; i++) begin
            if (w_push[i]) begin
                r_memData[w_slot[i]] <= w_word[i];
                r_memPc[w_slot[i]]   <= w_wordPc[i];
            end
        end
    end

    // Redirect handling sits after the FSM so it overrides fetch_pc and the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_fetchPc  <= entry;
            r_lineAddr <= '0;
            r_beat     <= '0;
            r_reqCyc   <= 1'b0;
            r_reqTag   <= '0;
            r_drain    <= 1'b0;
            r_halted   <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            if (w_zeroPush) begin
                r_halted <= 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_tail  <= r_tail + PTR_W'(w_pushCount);
            r_count <= r_count + w_pushCount - CNT_W'(w_pop);

            case (r_state)
                IDLE: begin
                    if (w_canFetch && !redirect_valid) begin
                        r_state    <= REQ;
                        r_reqCyc   <= 1'b1;
                        r_lineAddr <= r_fetchPc & LINE_MASK;
                        r_reqTag   <= READ_TAG;
                    end
                end
                REQ: begin
                    if (redirect_valid) begin
                        r_drain <= 1'b1;
                    end
                    if (bus_reqack) begin
                        r_state  <= READ;
                        r_reqCyc <= 1'b0;
                        r_beat   <= '0;
                    end
                end
                READ: begin
                    if (redirect_valid && !w_lastBeat) begin
                        r_drain <= 1'b1;
                    end
                    if (w_beatAcc) begin
                        r_beat <= r_beat + BEAT_W'(1);
                    end
                    if (w_lastBeat) begin
                        r_state <= IDLE;
                        r_drain <= 1'b0;
                        if (!r_drain && !redirect_valid) begin
                            r_fetchPc <= r_lineAddr + 64'(LINE_BYTES);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (redirect_valid) begin
                r_fetchPc <= redirect_pc;
                r_halted  <= 1'b0;
                r_head    <= '0;
                r_tail    <= '0;
                r_count   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a sysbus memory model answers line reads, a monitor
// logs every instruction handed to the consumer, and directed scenarios check them.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] entry;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack;
    logic        bus_respcyc;
    logic        bus_respack;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;
    logic        halted;

    int checks = 0;
    int passes = 0;

    // Memory model state
    int          phase = 0;
    int          waitCnt = 0;
    int          ackDelay = 0;
    int          beatIdx = 0;
    int          curBeat = -1;
    int          beatsAcked = 0;
    int          stabErr = 0;
    int          respAckErr = 0;
    bit          holdRespInReset = 1'b0;
    logic [63:0] lineAddr = '0;
    logic [63:0] zeroAddr = 64'hFFFF_FFFF_FFFF_FFF0;
    logic [12:0] tagSeen = '0;
    logic [63:0] reqQ[$];
    logic [63:0] instPcQ[$];
    logic [31:0] instDataQ[$];

    typedef struct {
        logic [63:0] entryPc;
        logic [63:0] zeroAt;
        logic [63:0] expReq;
        int          expCount;
        logic [63:0] expFirstPc;
        logic [31:0] expFirstData;
        logic        expHalted;
        logic        expNext;
        logic [63:0] expNextReq;
    } vec_t;

    vec_t vecs[5];

    fetch_unit dut (
        .clk(clk),
        .reset(reset),
        .entry(entry),
        .bus_reqcyc(bus_reqcyc),
        .bus_req(bus_req),
        .bus_reqtag(bus_reqtag),
        .bus_reqack(bus_reqack),
        .bus_respcyc(bus_respcyc),
        .bus_respack(bus_respack),
        .bus_resp(bus_resp),
        .bus_resptag(bus_resptag),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst_data(inst_data),
        .inst_pc(inst_pc),
        .halted(halted)
    );

    always #5 clk = ~clk;

    // Word at address a holds its word index plus one, except the planted zero
    function automatic logic [31:0] memWord(input logic [63:0] a);
        if (a == zeroAddr) return 32'h0;
        return a[33:2] + 32'd1;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic [63:0] e, input logic [63:0] z, input logic rdy, input int dly);
        @(posedge clk); #3;
        reset = 1'b1;
        entry = e;
        zeroAddr = z;
        inst_ready = rdy;
        ackDelay = dly;
        redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reqQ.delete();
        instPcQ.delete();
        instDataQ.delete();
        beatsAcked = 0;
        stabErr = 0;
        respAckErr = 0;
        reset = 1'b0;
    endtask

    // Sysbus responder: acks a request after ackDelay cycles, then streams 8 beats
    initial begin : busModel
        logic [63:0] addr;
        bus_reqack = 1'b0;
        bus_respcyc = 1'b0;
        bus_resp = '0;
        bus_resptag = '0;
        forever begin
            @(posedge clk); #1;
            bus_reqack = 1'b0;
            bus_respcyc = 1'b0;
            curBeat = -1;
            if (reset) begin
                phase = 0;
                bus_respcyc = holdRespInReset;
            end else begin
                if (phase == 0 && bus_reqcyc) begin
                    reqQ.push_back(bus_req);
                    lineAddr = bus_req;
                    tagSeen = bus_reqtag;
                    waitCnt = ackDelay;
                    phase = 1;
                end
                if (phase == 1) begin
                    if (!bus_reqcyc || bus_req !== lineAddr || bus_reqtag !== tagSeen) stabErr++;
                    if (waitCnt == 0) begin
                        bus_reqack = 1'b1;
                        phase = 2;
                        beatIdx = 0;
                    end else begin
                        waitCnt--;
                    end
                end else if (phase == 2) begin
                    curBeat = beatIdx;
                    addr = lineAddr + 64'(beatIdx * 8);
                    bus_resp = {memWord(addr + 64'd4), memWord(addr)};
                    bus_respcyc = 1'b1;
                    #1;
                    if (bus_respack !== 1'b1) respAckErr++;
                    beatsAcked++;
                    beatIdx++;
                    if (beatIdx == 8) phase = 0;
                end
            end
        end
    end

    // Log each instruction the consumer takes; the pop lands on the next rising edge
    always @(negedge clk) begin
        if (!reset && inst_valid && inst_ready && !redirect_valid) begin
            instPcQ.push_back(inst_pc);
            instDataQ.push_back(inst_data);
        end
    end

    initial begin : mainTest
        int lineCnt;
        int seqErr;
        int dataErr;
        int found;

        vecs[0] = '{64'h1000, 64'hFFFF_FFFF_FFFF_FFF0, 64'h1000, 16, 64'h1000, 32'h401, 1'b0, 1'b1, 64'h1040};
        vecs[1] = '{64'h1034, 64'hFFFF_FFFF_FFFF_FFF0, 64'h1000,  3, 64'h1034, 32'h40E, 1'b0, 1'b1, 64'h1040};
        vecs[2] = '{64'h1000, 64'h1008,                64'h1000,  3, 64'h1000, 32'h401, 1'b1, 1'b0, 64'h0};
        vecs[3] = '{64'h2010, 64'hFFFF_FFFF_FFFF_FFF0, 64'h2000, 12, 64'h2010, 32'h805, 1'b0, 1'b1, 64'h2040};
        vecs[4] = '{64'h3000, 64'h3034,                64'h3000, 14, 64'h3000, 32'hC01, 1'b1, 1'b0, 64'h0};

        reset = 1'b1;
        entry = 64'h1000;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_reqcyc", 64'(bus_reqcyc), 64'd0);
        checkOutput("rst_req", bus_req, 64'd0);
        checkOutput("rst_reqtag", 64'(bus_reqtag), 64'd0);
        checkOutput("rst_respack", 64'(bus_respack), 64'd0);
        checkOutput("rst_instvalid", 64'(inst_valid), 64'd0);
        checkOutput("rst_halted", 64'(halted), 64'd0);

        // Table-driven line fetches with a free-running consumer
        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].entryPc, vecs[v].zeroAt, 1'b1, 0);
            for (int c = 0; c < 120 && reqQ.size() < 2; c++) begin
                @(posedge clk); #3;
            end
            repeat (40) @(posedge clk);
            #3;
            lineCnt = 0;
            seqErr = 0;
            dataErr = 0;
            foreach (instPcQ[k]) begin
                if (instDataQ[k] !== memWord(instPcQ[k])) dataErr++;
                if (instPcQ[k] >= vecs[v].expReq && instPcQ[k] < vecs[v].expReq + 64'd64) begin
                    if (instPcQ[k] !== vecs[v].expFirstPc + 64'(4 * lineCnt)) seqErr++;
                    lineCnt++;
                end
            end
            checkOutput($sformatf("v%0d_req", v), reqQ.size() > 0 ? reqQ[0] : 64'hX, vecs[v].expReq);
            checkOutput($sformatf("v%0d_tag", v), 64'(tagSeen), 64'h1100);
            checkOutput($sformatf("v%0d_count", v), 64'(lineCnt), 64'(vecs[v].expCount));
            checkOutput($sformatf("v%0d_firstPc", v), instPcQ.size() > 0 ? instPcQ[0] : 64'hX, vecs[v].expFirstPc);
            checkOutput($sformatf("v%0d_firstData", v), instDataQ.size() > 0 ? 64'(instDataQ[0]) : 64'hX, 64'(vecs[v].expFirstData));
            checkOutput($sformatf("v%0d_seqErrs", v), 64'(seqErr), 64'd0);
            checkOutput($sformatf("v%0d_dataErrs", v), 64'(dataErr), 64'd0);
            checkOutput($sformatf("v%0d_respackErrs", v), 64'(respAckErr), 64'd0);
            checkOutput($sformatf("v%0d_halted", v), 64'(halted), 64'(vecs[v].expHalted));
            if (vecs[v].expNext) begin
                checkOutput($sformatf("v%0d_nextReq", v), reqQ.size() > 1 ? reqQ[1] : 64'hX, vecs[v].expNextReq);
            end else begin
                checkOutput($sformatf("v%0d_reqCount", v), 64'(reqQ.size()), 64'd1);
                checkOutput($sformatf("v%0d_beatsAcked", v), 64'(beatsAcked), 64'd8);
            end
        end

        // Stalled consumer: two lines fill the buffer, 16 pops free room for a third
        applyStimulus(64'h1000, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 0);
        repeat (100) @(posedge clk);
        #3;
        checkOutput("bp_reqCount", 64'(reqQ.size()), 64'd2);
        checkOutput("bp_req1", reqQ.size() > 1 ? reqQ[1] : 64'hX, 64'h1040);
        checkOutput("bp_valid", 64'(inst_valid), 64'd1);
        checkOutput("bp_headPc", inst_pc, 64'h1000);
        inst_ready = 1'b1;
        @(posedge clk); #3;
        inst_ready = 1'b0;
        repeat (30) @(posedge clk);
        #3;
        checkOutput("bp_onePopReqCount", 64'(reqQ.size()), 64'd2);
        checkOutput("bp_onePopHead", inst_pc, 64'h1004);
        inst_ready = 1'b1;
        repeat (15) @(posedge clk);
        #3;
        inst_ready = 1'b0;
        repeat (30) @(posedge clk);
        #3;
        checkOutput("bp_refillReqCount", 64'(reqQ.size()), 64'd3);
        checkOutput("bp_req2", reqQ.size() > 2 ? reqQ[2] : 64'hX, 64'h1080);

        // Redirect at beat 3 of a burst
        applyStimulus(64'h1000, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 0);
        found = 0;
        for (int c = 0; c < 50 && found == 0; c++) begin
            @(posedge clk); #3;
            if (curBeat == 3) found = 1;
        end
        checkOutput("rd_reachedBeat3", 64'(found), 64'd1);
        redirect_valid = 1'b1;
        redirect_pc = 64'h2008;
        @(posedge clk); #3;
        redirect_valid = 1'b0;
        checkOutput("rd_flushed", 64'(inst_valid), 64'd0);
        for (int c = 0; c < 20 && beatsAcked < 8; c++) begin
            @(posedge clk); #3;
        end
        @(posedge clk); #3;
        checkOutput("rd_beatsAcked", 64'(beatsAcked), 64'd8);
        checkOutput("rd_drainedEmpty", 64'(inst_valid), 64'd0);
        repeat (40) @(posedge clk);
        #3;
        checkOutput("rd_nextReq", reqQ.size() > 1 ? reqQ[1] : 64'hX, 64'h2000);
        checkOutput("rd_headPc", inst_pc, 64'h2008);
        checkOutput("rd_headData", 64'(inst_data), 64'h803);

        // Redirect while the request waits for its ack
        applyStimulus(64'h1000, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 5);
        for (int c = 0; c < 20 && phase != 1; c++) begin
            @(posedge clk); #3;
        end
        redirect_valid = 1'b1;
        redirect_pc = 64'h3004;
        @(posedge clk); #3;
        redirect_valid = 1'b0;
        @(negedge clk);
        checkOutput("rr_reqcycHeld", 64'(bus_reqcyc), 64'd1);
        checkOutput("rr_reqAddrHeld", bus_req, 64'h1000);
        repeat (60) @(posedge clk);
        #3;
        checkOutput("rr_stability", 64'(stabErr), 64'd0);
        checkOutput("rr_nextReq", reqQ.size() > 1 ? reqQ[1] : 64'hX, 64'h3000);
        checkOutput("rr_headPc", inst_pc, 64'h3004);

        // Slow ack keeps the request stable, then reset lands mid-burst
        applyStimulus(64'h1000, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 5);
        found = 0;
        for (int c = 0; c < 60 && found == 0; c++) begin
            @(posedge clk); #3;
            if (curBeat == 2) found = 1;
        end
        checkOutput("ra_reachedBeat2", 64'(found), 64'd1);
        checkOutput("ra_stability", 64'(stabErr), 64'd0);
        checkOutput("ra_req0", reqQ.size() > 0 ? reqQ[0] : 64'hX, 64'h1000);
        holdRespInReset = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("ra_respackInReset", 64'(bus_respack), 64'd0);
        checkOutput("ra_reqcycInReset", 64'(bus_reqcyc), 64'd0);
        checkOutput("ra_validInReset", 64'(inst_valid), 64'd0);
        @(posedge clk); #3;
        reset = 1'b0;
        holdRespInReset = 1'b0;
        repeat (30) @(posedge clk);
        #3;
        checkOutput("ra_restartReq", reqQ.size() > 1 ? reqQ[1] : 64'hX, 64'h1000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter BUS_DATA_WIDTH, default 64: Sysbus data width in bits; a multiple of 32.
REQ-003 Parameter BUS_TAG_WIDTH, default 13: Sysbus tag width.
REQ-004 Parameter LINE_BYTES, default 64: bytes per burst; a power of two and a multiple of BUS_DATA_WIDTH/8.
REQ-005 Parameter FIFO_DEPTH, default 32: instruction buffer entries; a power of two and at least LINE_BYTES/4.
REQ-006 The ports SHALL be, in order:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- entry  in  64  start PC, sampled during reset
- bus_reqcyc  out  1  request valid
- bus_req  out  BUS_DATA_WIDTH  request address
- bus_reqtag  out  BUS_TAG_WIDTH  request tag
- bus_reqack  in  1  request accepted
- bus_respcyc  in  1  response beat valid
- bus_respack  out  1  response beat accepted
- bus_resp  in  BUS_DATA_WIDTH  response data
- bus_resptag  in  BUS_TAG_WIDTH  response tag (ignored)
- redirect_valid  in  1  redirect fetch
- redirect_pc  in  64  redirect target, 4-byte aligned
- inst_valid  out  1  instruction available
- inst_ready  in  1  consumer accepts instruction
- inst_data  out  32  instruction word
- inst_pc  out  64  address of inst_data
- halted  out  1  all-zero instruction fetched

Function
REQ-007 Definitions: IPB = BUS_DATA_WIDTH/32 instructions per beat; BPL = LINE_BYTES*8/BUS_DATA_WIDTH beats per line; IPL = LINE_BYTES/4 instructions per line.
REQ-008 The FSM SHALL have states IDLE, REQ and READ.
REQ-009 IDLE -> REQ SHALL occur when halted=0 and the number of free FIFO entries is at least IPL.
REQ-010 In REQ, the block SHALL drive the following, all held stable until bus_reqack=1, after which the FSM enters READ on the next cycle:
- bus_reqcyc=1
- bus_req = fetch_pc with its low log2(LINE_BYTES) bits cleared
- bus_reqtag = (`SYSBUS_READ<<8)|(`SYSBUS_MEMORY<<12)
REQ-011 In READ, bus_respack SHALL equal bus_respcyc combinationally; each beat with bus_respcyc=1 SHALL be accepted and SHALL increment a beat counter.
REQ-012 Each accepted beat SHALL split into IPB 32-bit words, lowest bits first; word i of beat b SHALL have address line_addr + b*BUS_DATA_WIDTH/8 + 4*i.
REQ-013 A word SHALL be pushed into the FIFO only when all of the following hold:
- its address >= fetch_pc
- halted=0
- the drain flag is clear
REQ-014 After beat BPL-1 is accepted, the FSM SHALL return to IDLE and fetch_pc SHALL become line_addr + LINE_BYTES (64-bit wrap-around).
REQ-015 A pushed word equal to 32'h0 SHALL be pushed and SHALL set halted on the next cycle; later words in the same beat SHALL NOT be pushed.
REQ-016 While halted=1, remaining beats SHALL still be acked, and no new requests SHALL be issued.
REQ-017 inst_valid SHALL be 1 whenever the FIFO is non-empty; inst_data and inst_pc SHALL show the FIFO head.
REQ-018 The head SHALL pop on inst_valid & inst_ready.
REQ-019 A push and a pop in the same cycle SHALL both take effect.
REQ-020 When the FIFO is full, inst_valid SHALL remain 1 and no pushes SHALL occur; overflow is impossible by REQ-009.
REQ-021 On redirect_valid=1, the next cycle SHALL have:
- FIFO emptied
- fetch_pc = redirect_pc
- halted=0
Any push or pop in the redirect cycle SHALL be discarded.
REQ-022 A redirect in REQ SHALL NOT drop bus_reqcyc before bus_reqack; the burst SHALL then complete with the drain flag set.
REQ-023 A redirect in READ SHALL set the drain flag; remaining beats SHALL be acked but not pushed.
REQ-024 The drain flag SHALL clear on return to IDLE, and fetch_pc SHALL NOT advance at the end of a drained burst.

Reset
REQ-025 While reset=1, the block SHALL set:
- fetch_pc=entry
- FSM=IDLE
- FIFO empty
- drain=0, halted=0
- bus_reqcyc=0, bus_respack=0, inst_valid=0
- bus_req=0, bus_reqtag=0
REQ-026 Reset asserted mid-burst SHALL abandon the burst immediately; the bus is reset in the same cycle.

Verification
REQ-027 Defaults, entry=0x1000, memory words = index+1, inst_ready=1 -> one request at 0x1000, then 8 beats, then 16 instructions with inst_pc 0x1000..0x103C; next request at 0x1040.
REQ-028 entry=0x1034 -> request at 0x1000; only PCs 0x1034, 0x1038 and 0x103C are emitted; next request at 0x1040.
REQ-029 Word at 0x1008 = 0 -> instructions 0x1000, 0x1004 and 0x1008 (data 0) are emitted; halted=1; all 8 beats acked; no further bus_reqcyc.
REQ-030 inst_ready=0, FIFO_DEPTH=32 -> two lines fetched, then inst_valid=1 with no third request; one pop leaves no request; 16 pops trigger a request.
REQ-031 redirect_pc=0x2008 at beat 3 of a burst -> beats 4-7 acked and discarded; inst_valid=0; next request at 0x2000; first inst_pc=0x2008.
REQ-032 bus_reqack held 0 for 5 cycles -> bus_req and bus_reqtag stable; bus_reqcyc=1 throughout; reset mid-READ -> bus_respack=0 and bus_reqcyc=0 next cycle.
